// File: rtl/muldiv_pkg.sv
// Shared encodings for the RV32M-style iterative multiply/divide unit:
// FSM states, the M-extension Funct7 tag and the Funct3 operation codes.
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

endpackage

// File: rtl/rv_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, signs re-applied when loading Result.
//   state | meaning
//   IDLE  | waiting for an accepted start
//   CALC  | one multiply/divide iteration per cycle, WIDTH iterations
//   DONE  | Result valid, done pulses for this single cycle
module rv_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic [6:0]       Funct7,
    input  logic [2:0]       Funct3,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result
);
    import muldiv_pkg::*;

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic is_signed);
        return (is_signed && v[WIDTH-1]) ? -v : v;
    endfunction

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic             neg_q, neg_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic             a_signed, b_signed, sign_a, sign_b, neg_in;
    logic             div_zero, div_ovf, accept;
    logic [WIDTH-1:0] mag_a, mag_b, special_res;

    logic [WIDTH:0]     mul_sum, div_shift, div_trial;
    logic [WIDTH-1:0]   step_hi, step_lo;
    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0]   quo_s, rem_s, final_res;

    // Operand decode for the start request
    always_comb begin
        a_signed = (Funct3 == F3_MULH) || (Funct3 == F3_MULHSU) ||
                   (Funct3 == F3_DIV)  || (Funct3 == F3_REM);
        b_signed = (Funct3 == F3_MULH) || (Funct3 == F3_DIV) || (Funct3 == F3_REM);
        sign_a   = a_signed & SrcA[WIDTH-1];
        sign_b   = b_signed & SrcB[WIDTH-1];
        neg_in   = (Funct3 == F3_REM) ? sign_a : (sign_a ^ sign_b);
        mag_a    = magnitude(SrcA, a_signed);
        mag_b    = magnitude(SrcB, b_signed);
        div_zero = Funct3[2] && (SrcB == '0);
        div_ovf  = ((Funct3 == F3_DIV) || (Funct3 == F3_REM)) &&
                   (SrcA == MIN_NEG) && (SrcB == '1);
        accept   = (state_q == IDLE) && start && !flush && (Funct7 == FUNCT7_MULDIV);

        special_res = '0;
        if (div_zero) begin
            special_res = Funct3[1] ? SrcA : '1;
        end else if (div_ovf) begin
            special_res = Funct3[1] ? '0 : SrcA;
        end
    end

    // One iteration of either datapath, from the current registers
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, b_q};

        if (op_q[2]) begin
            if (!div_trial[WIDTH]) begin
                step_hi = div_trial[WIDTH-1:0];
                step_lo = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = div_shift[WIDTH-1:0];
                step_lo = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
        end

        prod   = {step_hi, step_lo};
        prod_s = neg_q ? -prod : prod;
        quo_s  = neg_q ? -step_lo : step_lo;
        rem_s  = neg_q ? -step_hi : step_hi;

        if (op_q[2]) begin
            final_res = op_q[1] ? rem_s : quo_s;
        end else if (op_q == F3_MUL) begin
            final_res = prod_s[WIDTH-1:0];
        end else begin
            final_res = prod_s[2*WIDTH-1:WIDTH];
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        neg_d    = neg_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d  = Funct3;
                    neg_d = neg_in;
                    cnt_d = '0;
                    if (div_zero || div_ovf) begin
                        result_d = special_res;
                        state_d  = DONE;
                    end else begin
                        b_d     = mag_b;
                        hi_d    = '0;
                        lo_d    = mag_a;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    hi_d  = step_hi;
                    lo_d  = step_lo;
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        result_d = final_res;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= '0;
            neg_q    <= 1'b0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign Result = result_q;

endmodule
